pipe_scoreboard_hazard_unit: RTL and testbench
==============================================

Name: pipe_scoreboard_hazard_unit

Overview:
Parametrised hazard controller for the next-generation RISC-V pipeline. It tracks long-latency writebacks (div, mul, multi-cycle load) in a per-register scoreboard and stalls issue on RAW/WAW or on a full in-flight budget. It also sequences mispredict/exception recovery through a flush/drain/redirect FSM. It sits beside decode and drives pc_en, stall, the stage flushes and the redirect PC to fetch.

Parameters:
NUM_RS, 2, number of source-register read ports checked per issue
REG_ADDR_W, 5, register address width; scoreboard has 2**REG_ADDR_W entries
MAX_INFLIGHT, 4, max outstanding long-latency ops; must be >=1
PC_W, 32, width of PC/target buses

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
issue_valid  in  1  decode presents an instruction
issue_rs  in  NUM_RS*REG_ADDR_W  packed source addrs; port k at [k*REG_ADDR_W +: REG_ADDR_W]
issue_rs_used  in  NUM_RS  per-port "source actually read"
issue_rd  in  REG_ADDR_W  destination
issue_long  in  1  instruction writes rd later via wb port
wb_valid  in  1  long-latency result written back this cycle
wb_rd  in  REG_ADDR_W  writeback destination
i_mem_busy  in  1  fetch memory busy
d_mem_busy  in  1  data memory busy
mispredict  in  1  branch/jump resolved wrong
brj_addr  in  PC_W  correct branch target
exception  in  1  trap taken
priv_pc  in  PC_W  trap vector
halt  in  1  halt instruction reached
stall  out  1  hold decode; issue not accepted
pc_en  out  1  pipeline advance enable
if_id_flush  out  1  flush IF/ID
id_ex_flush  out  1  flush ID/EX
ex_mem_flush  out  1  flush EX/MEM
npc_sel  out  1  fetch selects redirect_pc
redirect_pc  out  PC_W  latched redirect target
inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding long ops
sb_err  out  1  sticky: wb to non-busy register

Behaviour:
- Reset (nRST low, async): scoreboard all 0, inflight 0, state IDLE, redirect_pc 0, sb_err 0. Outputs decode from this state: stall 0, flushes 0, npc_sel 0.
- Register 0 is never marked busy; rs/rd of 0 never hazard.
- raw = OR over k of (issue_rs_used[k] & rs_k!=0 & sb[rs_k]). waw = issue_long & issue_rd!=0 & sb[issue_rd]. full = issue_long & inflight==MAX_INFLIGHT.
- stall = issue_valid & (raw|waw|full) in IDLE; stall=1 in every non-IDLE state.
- accept = issue_valid & ~stall & state==IDLE. On accept with issue_long & rd!=0: set sb[rd], inflight+1 next edge.
- wb_valid with sb[wb_rd]=1: clear bit, inflight-1. wb_valid with sb[wb_rd]=0 (or rd 0): no change, sb_err<=1 (sticky until reset).
- Set and clear in the same cycle: inflight unchanged. If same register: set wins (bit stays 1).
- inflight never wraps; full stall guarantees no overflow.
- pc_en in IDLE = ~stall & ~i_mem_busy & ~d_mem_busy.
- FSM states: IDLE, FLUSH, DRAIN, REDIRECT, HALTED.
- IDLE: exception -> FLUSH with redirect_pc<=priv_pc; else mispredict -> FLUSH with redirect_pc<=brj_addr; else halt -> HALTED. Exception has priority over mispredict, and both over halt.
- FLUSH (1 cycle): if_id/id_ex/ex_mem_flush=1, pc_en=0 -> DRAIN.
- DRAIN: pc_en=0, flushes 0; exit to REDIRECT when i_mem_busy=0 & d_mem_busy=0. An exception arriving in DRAIN re-latches redirect_pc<=priv_pc and stays in DRAIN. A mispredict in DRAIN is ignored.
- REDIRECT (1 cycle): npc_sel=1, pc_en=1 -> IDLE.
- HALTED: pc_en=0, stall=1, absorbing until reset.
- Flushes do not touch the scoreboard; in-flight long ops still retire via wb.
- Reset asserted in any state returns to IDLE immediately.

Optional Feature:
SCOREBOARD_WB_BYPASS_EN: when defined, a wb_valid to register r in the same cycle masks sb[r] for the raw/waw checks, so an instruction reading r issues that cycle. This matches a register file with write-before-read. When undefined, the hazard uses the registered scoreboard only, and the consumer issues one cycle after writeback.

Test Plan:
- Issue long rd=5 at cycle 0; issue rs1=5 at cycle 1 -> stall=1 until wb_valid rd=5. With bypass the consumer issues in the wb cycle; without bypass it issues the next cycle. inflight goes 1->0.
- MAX_INFLIGHT=4: issue long rd=1..4 with no wb -> inflight=4. Fifth long rd=6 stalls. A non-long op with unrelated sources is accepted.
- Same cycle: wb rd=7 and accept long rd=7 -> sb[7]=1, inflight unchanged. Also issue rd=0 long -> no bit set, inflight unchanged.
- mispredict with brj_addr=0x100, d_mem_busy high 3 cycles -> FLUSH 1 cycle (all flushes=1), DRAIN 3 cycles, then REDIRECT with npc_sel=1 and redirect_pc=0x100, then IDLE.
- mispredict then exception (priv_pc=0x8000_0004) during DRAIN -> redirect_pc=0x8000_0004 at REDIRECT. Simultaneous exception+mispredict in IDLE -> priv_pc chosen.
- wb_valid rd=9 while not busy -> sb_err=1 and stays 1. halt -> pc_en=0 permanently; nRST pulse mid-DRAIN -> IDLE with all outputs at reset values.

Source files
------------

// File: rtl/pipe_scoreboard_hazard_unit.sv
// Issue hazard controller: per-register long-latency scoreboard plus a flush/drain/redirect recovery FSM.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear the hazard on its register.
module pipe_scoreboard_hazard_unit #(
  parameter int NUM_RS       = 2,
  parameter int REG_ADDR_W   = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int PC_W         = 32
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic                                  issue_valid,
  input  logic [NUM_RS*REG_ADDR_W-1:0]          issue_rs,
  input  logic [NUM_RS-1:0]                     issue_rs_used,
  input  logic [REG_ADDR_W-1:0]                 issue_rd,
  input  logic                                  issue_long,
  input  logic                                  wb_valid,
  input  logic [REG_ADDR_W-1:0]                 wb_rd,
  input  logic                                  i_mem_busy,
  input  logic                                  d_mem_busy,
  input  logic                                  mispredict,
  input  logic [PC_W-1:0]                       brj_addr,
  input  logic                                  exception,
  input  logic [PC_W-1:0]                       priv_pc,
  input  logic                                  halt,
  output logic                                  stall,
  output logic                                  pc_en,
  output logic                                  if_id_flush,
  output logic                                  id_ex_flush,
  output logic                                  ex_mem_flush,
  output logic                                  npc_sel,
  output logic [PC_W-1:0]                       redirect_pc,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
  output logic                                  sb_err
);

  localparam int CNT_W    = $clog2(MAX_INFLIGHT + 1);
  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  typedef enum logic [2:0] {IDLE, FLUSH, DRAIN, REDIRECT, HALTED} state_e;

  state_e              state, state_nxt;
  logic [NUM_REGS-1:0] sb, sb_hz, sb_nxt;
  logic [CNT_W-1:0]    inflight_nxt;
  logic [PC_W-1:0]     redirect_nxt;
  logic                raw, waw, full, hazard, idle_stall;
  logic                accept, sb_set, sb_clr, wb_err;

  always_comb begin
    sb_hz = sb;
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_valid) sb_hz[wb_rd] = 1'b0;
`endif
  end

  always_comb begin
    raw = 1'b0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      if (issue_rs_used[k] && (issue_rs[k*REG_ADDR_W +: REG_ADDR_W] != '0) &&
          sb_hz[issue_rs[k*REG_ADDR_W +: REG_ADDR_W]])
        raw = 1'b1;
    end
  end

  assign waw        = issue_long && (issue_rd != '0) && sb_hz[issue_rd];
  assign full       = issue_long && (inflight == CNT_W'(MAX_INFLIGHT));
  assign hazard     = raw || waw || full;
  assign idle_stall = issue_valid && hazard;
  assign accept     = issue_valid && !hazard && (state == IDLE);
  assign sb_set     = accept && issue_long && (issue_rd != '0);
  // sb[0] is never set, so a writeback to x0 always lands in the error path.
  assign sb_clr     = wb_valid && sb[wb_rd];
  assign wb_err     = wb_valid && !sb[wb_rd];

  // Clear is applied before set so a same-register set/clear leaves the bit busy.
  always_comb begin
    sb_nxt = sb;
    if (sb_clr) sb_nxt[wb_rd] = 1'b0;
    if (sb_set) sb_nxt[issue_rd] = 1'b1;
    inflight_nxt = inflight;
    if (sb_set && !sb_clr)      inflight_nxt = inflight + 1'b1;
    else if (sb_clr && !sb_set) inflight_nxt = inflight - 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    redirect_nxt = redirect_pc;
    stall        = 1'b1;
    pc_en        = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    npc_sel      = 1'b0;
    case (state)
      IDLE: begin
        stall = idle_stall;
        pc_en = !idle_stall && !i_mem_busy && !d_mem_busy;
        if (exception) begin
          state_nxt    = FLUSH;
          redirect_nxt = priv_pc;
        end else if (mispredict) begin
          state_nxt    = FLUSH;
          redirect_nxt = brj_addr;
        end else if (halt) begin
          state_nxt = HALTED;
        end
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        state_nxt    = DRAIN;
      end
      DRAIN: begin
        // A late exception retargets recovery and holds off the exit for one more cycle.
        if (exception)                         redirect_nxt = priv_pc;
        else if (!i_mem_busy && !d_mem_busy)   state_nxt    = REDIRECT;
      end
      REDIRECT: begin
        npc_sel   = 1'b1;
        pc_en     = 1'b1;
        state_nxt = IDLE;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      sb          <= '0;
      inflight    <= '0;
      redirect_pc <= '0;
      sb_err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      sb          <= sb_nxt;
      inflight    <= inflight_nxt;
      redirect_pc <= redirect_nxt;
      if (wb_err) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard_hazard_unit.sv
// Scoreboard bench for pipe_scoreboard_hazard_unit: directed stimulus queues expectations, a monitor checks them.
module tb_pipe_scoreboard_hazard_unit;

  localparam int NUM_RS       = 2;
  localparam int REG_ADDR_W   = 5;
  localparam int MAX_INFLIGHT = 4;
  localparam int PC_W         = 32;
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1);

  logic                          CLK = 1'b0;
  logic                          nRST = 1'b0;
  logic                          issue_valid, issue_long, wb_valid;
  logic [NUM_RS*REG_ADDR_W-1:0]  issue_rs;
  logic [NUM_RS-1:0]             issue_rs_used;
  logic [REG_ADDR_W-1:0]         issue_rd, wb_rd;
  logic                          i_mem_busy, d_mem_busy, mispredict, exception, halt;
  logic [PC_W-1:0]               brj_addr, priv_pc;
  logic                          stall, pc_en, if_id_flush, id_ex_flush, ex_mem_flush, npc_sel, sb_err;
  logic [PC_W-1:0]               redirect_pc;
  logic [CNT_W-1:0]              inflight;

  pipe_scoreboard_hazard_unit #(
    .NUM_RS(NUM_RS), .REG_ADDR_W(REG_ADDR_W), .MAX_INFLIGHT(MAX_INFLIGHT), .PC_W(PC_W)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
    .issue_rd(issue_rd), .issue_long(issue_long),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .i_mem_busy(i_mem_busy), .d_mem_busy(d_mem_busy),
    .mispredict(mispredict), .brj_addr(brj_addr),
    .exception(exception), .priv_pc(priv_pc), .halt(halt),
    .stall(stall), .pc_en(pc_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .npc_sel(npc_sel), .redirect_pc(redirect_pc), .inflight(inflight), .sb_err(sb_err)
  );

  always #5 CLK = ~CLK;

  typedef enum int {S_STALL, S_PCEN, S_IFF, S_IDF, S_EMF, S_NPC, S_RPC, S_INF, S_ERR} sig_e;
  typedef struct {
    int unsigned cyc;
    string       name;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] probe(sig_e s);
    case (s)
      S_STALL: return {31'd0, stall};
      S_PCEN:  return {31'd0, pc_en};
      S_IFF:   return {31'd0, if_id_flush};
      S_IDF:   return {31'd0, id_ex_flush};
      S_EMF:   return {31'd0, ex_mem_flush};
      S_NPC:   return {31'd0, npc_sel};
      S_RPC:   return 32'(redirect_pc);
      S_INF:   return 32'(inflight);
      default: return {31'd0, sb_err};
    endcase
  endfunction

  always @(negedge CLK) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = probe(e.sig);
      n_chk++;
      if (act === e.val) n_pass++;
      else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", e.name, cyc, act, e.val);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ex(string n, sig_e s, logic [31:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.name = n;
    e.sig  = s;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic ctl(string n, logic [31:0] st, logic [31:0] pe, logic [31:0] fl, logic [31:0] np);
    ex({n, "_stall"}, S_STALL, st);
    ex({n, "_pc_en"}, S_PCEN, pe);
    ex({n, "_if_id_flush"}, S_IFF, fl);
    ex({n, "_id_ex_flush"}, S_IDF, fl);
    ex({n, "_ex_mem_flush"}, S_EMF, fl);
    ex({n, "_npc_sel"}, S_NPC, np);
  endtask

  task automatic issue(input int v, input int lng, input int rd,
                       input int rs0, input int u0, input int rs1, input int u1);
    issue_valid   = v[0];
    issue_long    = lng[0];
    issue_rd      = REG_ADDR_W'(rd);
    issue_rs      = {REG_ADDR_W'(rs1), REG_ADDR_W'(rs0)};
    issue_rs_used = {u1[0], u0[0]};
  endtask

  task automatic idle_in();
    issue(0, 0, 0, 0, 0, 0, 0);
    wb_valid   = 1'b0;
    wb_rd      = '0;
    i_mem_busy = 1'b0;
    d_mem_busy = 1'b0;
    mispredict = 1'b0;
    exception  = 1'b0;
    halt       = 1'b0;
    brj_addr   = '0;
    priv_pc    = '0;
  endtask

  initial begin
    idle_in();
    nRST = 1'b0;
    tick();
    ctl("rst", 0, 1, 0, 0);
    ex("rst_inflight", S_INF, 0);
    ex("rst_sb_err", S_ERR, 0);
    ex("rst_redirect_pc", S_RPC, 0);
    n_chk++;
    if (inflight === '0 && stall === 1'b0) n_pass++;
    else $display("FAIL rst_direct: inflight=%0d stall=%b", inflight, stall);
    nRST = 1'b1;

    tick(); issue(1, 1, 5, 0, 0, 0, 0); ex("long5_accept", S_STALL, 0);
    tick(); issue(1, 0, 10, 5, 1, 0, 0);
    ex("raw5_stall", S_STALL, 1); ex("raw5_pc_en", S_PCEN, 0); ex("inflight_1", S_INF, 1);
    n_chk++;
    if (stall === 1'b1 && inflight === CNT_W'(1)) n_pass++;
    else $display("FAIL raw5_direct: stall=%b inflight=%0d", stall, inflight);
    tick(); ex("raw5_hold", S_STALL, 1);
    tick(); wb_valid = 1'b1; wb_rd = 5;
`ifdef SCOREBOARD_WB_BYPASS_EN
    ex("raw5_wb_cycle_bypass", S_STALL, 0);
`else
    ex("raw5_wb_cycle_no_bypass", S_STALL, 1);
`endif
    ex("inflight_wb_cycle", S_INF, 1);
    tick(); wb_valid = 1'b0; ex("raw5_released", S_STALL, 0); ex("inflight_0", S_INF, 0);

    for (int r = 1; r <= 4; r++) begin
      tick(); issue(1, 1, r, 0, 0, 0, 0); ex("fill_accept", S_STALL, 0);
    end
    tick(); issue(1, 1, 6, 0, 0, 0, 0); ex("full_stall", S_STALL, 1); ex("inflight_4", S_INF, 4);
    tick(); issue(1, 0, 8, 9, 1, 10, 1); ex("short_unrelated_ok", S_STALL, 0);
    tick(); issue(1, 0, 8, 9, 1, 3, 1); ex("raw_port1", S_STALL, 1);
    tick(); issue(1, 0, 8, 9, 1, 3, 0); ex("rs_unused_ok", S_STALL, 0);

    tick(); issue(0, 0, 0, 0, 0, 0, 0); wb_valid = 1'b1; wb_rd = 1; ex("inflight_4b", S_INF, 4);
    tick(); wb_rd = 2; issue(1, 1, 7, 0, 0, 0, 0);
    ex("set_clr_accept", S_STALL, 0); ex("inflight_3a", S_INF, 3);
    tick(); wb_valid = 1'b0; issue(1, 0, 8, 7, 1, 0, 0);
    ex("set_clr_inflight", S_INF, 3); ex("raw7_stall", S_STALL, 1);
    tick(); issue(1, 1, 3, 0, 0, 0, 0); ex("waw3_stall", S_STALL, 1);
    tick(); issue(1, 1, 0, 0, 0, 0, 0); ex("rd0_accept", S_STALL, 0);
    tick(); issue(0, 0, 0, 0, 0, 0, 0); ex("rd0_inflight", S_INF, 3);
    tick(); wb_valid = 1'b1; wb_rd = 3;
    tick(); wb_rd = 4;
    tick(); wb_rd = 7;
    tick(); wb_valid = 1'b0; ex("inflight_drained", S_INF, 0); ex("no_sb_err", S_ERR, 0);

    tick(); mispredict = 1'b1; brj_addr = 32'h100; d_mem_busy = 1'b1; ctl("mp_idle", 0, 0, 0, 0);
    tick(); mispredict = 1'b0; ctl("flush", 1, 0, 1, 0); ex("rpc_brj", S_RPC, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick(); if (i == 2) d_mem_busy = 1'b0; ctl("drain", 1, 0, 0, 0);
    end
    tick(); ctl("redirect", 1, 1, 0, 1); ex("rpc_redirect", S_RPC, 32'h100);
    n_chk++;
    if (npc_sel === 1'b1 && redirect_pc === 32'h100) n_pass++;
    else $display("FAIL redirect_direct: npc_sel=%b redirect_pc=0x%0h", npc_sel, redirect_pc);
    tick(); ctl("back_idle", 0, 1, 0, 0);

    tick(); mispredict = 1'b1; brj_addr = 32'h200; d_mem_busy = 1'b1;
    tick(); mispredict = 1'b0; ex("rpc_200", S_RPC, 32'h200);
    tick(); exception = 1'b1; priv_pc = 32'h8000_0004; ctl("drain_exc", 1, 0, 0, 0);
    tick(); exception = 1'b0; mispredict = 1'b1; brj_addr = 32'h300;
    ex("rpc_exc_relatch", S_RPC, 32'h8000_0004);
    tick(); mispredict = 1'b0; d_mem_busy = 1'b0;
    ctl("drain_end", 1, 0, 0, 0); ex("rpc_mp_ignored", S_RPC, 32'h8000_0004);
    tick(); ctl("redirect2", 1, 1, 0, 1); ex("rpc_redirect2", S_RPC, 32'h8000_0004);
    tick(); exception = 1'b1; priv_pc = 32'h40; mispredict = 1'b1; brj_addr = 32'h500;
    ctl("idle2", 0, 1, 0, 0);
    tick(); exception = 1'b0; mispredict = 1'b0;
    ctl("flush3", 1, 0, 1, 0); ex("rpc_exc_priority", S_RPC, 32'h40);
    tick(); ctl("drain3", 1, 0, 0, 0);
    tick(); ctl("redirect3", 1, 1, 0, 1);
    tick();

    tick(); wb_valid = 1'b1; wb_rd = 9; ex("err_before", S_ERR, 0);
    tick(); wb_valid = 1'b0; ex("err_set", S_ERR, 1); ex("err_inflight", S_INF, 0);
    tick();
    tick(); ex("err_sticky", S_ERR, 1);
    n_chk++;
    if (sb_err === 1'b1) n_pass++;
    else $display("FAIL err_sticky_direct: sb_err=%b", sb_err);

    tick(); issue(1, 1, 12, 0, 0, 0, 0);
    tick(); issue(0, 0, 0, 0, 0, 0, 0); halt = 1'b1; ex("inflight_pre_halt", S_INF, 1);
    tick(); halt = 1'b0; exception = 1'b1; ctl("halted", 1, 0, 0, 0);
    tick(); exception = 1'b0; ctl("halted2", 1, 0, 0, 0); ex("halted_rpc", S_RPC, 32'h40);
    tick(); nRST = 1'b0;
    ctl("rst_halt", 0, 1, 0, 0);
    ex("rst_halt_inflight", S_INF, 0); ex("rst_halt_err", S_ERR, 0); ex("rst_halt_rpc", S_RPC, 0);
    tick(); nRST = 1'b1; issue(1, 0, 1, 12, 1, 0, 0); ex("sb_cleared_by_rst", S_STALL, 0);

    tick(); issue(0, 0, 0, 0, 0, 0, 0); mispredict = 1'b1; brj_addr = 32'h600; i_mem_busy = 1'b1;
    tick(); mispredict = 1'b0;
    tick(); ctl("drain4", 1, 0, 0, 0);
    tick(); nRST = 1'b0; i_mem_busy = 1'b0;
    ctl("rst_drain", 0, 1, 0, 0); ex("rst_drain_rpc", S_RPC, 0);
    tick(); nRST = 1'b1;
    tick(); ctl("idle_after_rst", 0, 1, 0, 0);

    tick(); tick();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      $display("FAIL %s: never compared, expected 0x%0h", e.name, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    if (n_pass == n_chk) $display("TEST PASSED");
    else $display("TEST FAILED");
    $finish;
  end

endmodule
